// File: rtl/fb_cpu_pkg.sv
// Shared definitions for the fb_cpu accumulator machine: opcode and state encodings.
// Opcode 5 (DIV) is only decoded as legal when FB_CPU_DIV_EN is defined.
package fb_cpu_pkg;

   localparam int OPC_W = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_LOD  = 4'd0,
      OP_STO  = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_MUL  = 4'd4,
      OP_DIV  = 4'd5,
      OP_JMP  = 4'd6,
      OP_JMZ  = 4'd7,
      OP_NOP  = 4'd8,
      OP_HLT  = 4'd9,
      OP_AND  = 4'd10,
      OP_OR   = 4'd11,
      OP_JMN  = 4'd12,
      OP_IL13 = 4'd13,
      OP_IL14 = 4'd14,
      OP_IL15 = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_e;

endpackage

// File: rtl/fb_cpu_gen2_if.sv
// Memory bus between the fb_cpu_gen2 core (master) and its program/data memory (slave).
interface fb_cpu_gen2_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 10
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/fb_cpu_alu.sv
// Combinational accumulator ALU: acc op memory-word -> new acc value.
// The divider only exists when FB_CPU_DIV_EN is defined.
module fb_cpu_alu
   import fb_cpu_pkg::*;
#(
   parameter int DATA_W = 10
) (
   input  opcode_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              div_zero
);

   always_comb begin
      result   = a;
      div_zero = 1'b0;
      case (op)
         OP_LOD: result = b;
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_MUL: result = a * b;
`ifdef FB_CPU_DIV_EN
         OP_DIV: begin
            if (b == '0) begin
               result   = '1;
               div_zero = 1'b1;
            end else begin
               result = a / b;
            end
         end
`endif
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         default: result = a;
      endcase
   end

endmodule

// File: rtl/fb_cpu_gen2.sv
// Multi-cycle accumulator CPU with a single request/ready memory port.
// Optional divide instruction enabled by defining FB_CPU_DIV_EN.
//
// state     | meaning
// FETCH     | read instruction at pc, latch IR, pc+1
// DECODE    | resolve branches/NOP/HLT/illegal, no memory access
// EXEC      | operand read (acc update) or STO write at operand address
// HALT      | idle with halted=1 until run=1
module fb_cpu_gen2
   import fb_cpu_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   fb_cpu_gen2_if.master     mem,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              halted,
   output logic              err
);

   if (DATA_W < ADDR_W + OPC_W) begin : g_param_check
      $error("fb_cpu_gen2: DATA_W must be at least ADDR_W+4");
   end

   state_e            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              err_q, err_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   opcode_e           op_q, op_d;
   logic [ADDR_W-1:0] operand_q;
   logic              accept;
   logic [DATA_W-1:0] alu_result;
   logic              alu_div_zero;

   assign op_q      = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
   assign operand_q = ir_q[ADDR_W-1:0];
   // mem_ready only counts while a request is actually presented
   assign accept    = req_q && mem.mem_ready;

   if (DATA_W > ADDR_W + OPC_W) begin : g_ir_pad
      logic unused_ir_pad;
      assign unused_ir_pad = ^ir_q[DATA_W-OPC_W-1:ADDR_W];
   end

   fb_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op       (op_q),
      .a        (acc_q),
      .b        (mem.mem_rdata),
      .result   (alu_result),
      .div_zero (alu_div_zero)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      err_d   = err_q;
      op_d    = op_q;
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         ST_FETCH: begin
            if (accept) begin
               ir_d    = mem.mem_rdata;
               pc_d    = pc_q + 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (op_q)
               OP_LOD, OP_STO, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR:
                  state_d = ST_EXEC;
`ifdef FB_CPU_DIV_EN
               OP_DIV: state_d = ST_EXEC;
`endif
               OP_JMP: begin
                  pc_d    = operand_q;
                  state_d = ST_FETCH;
               end
               OP_JMZ: begin
                  if (acc_q == '0) pc_d = operand_q;
                  state_d = ST_FETCH;
               end
               OP_JMN: begin
                  if (acc_q[DATA_W-1]) pc_d = operand_q;
                  state_d = ST_FETCH;
               end
               OP_NOP: state_d = ST_FETCH;
               OP_HLT: state_d = ST_HALT;
               default: begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end
            endcase
         end
         ST_EXEC: begin
            if (accept) begin
               if (op_q != OP_STO) acc_d = alu_result;
               if (alu_div_zero) err_d = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
            if (run) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase

      // Bus outputs are registered from the next state so they stay glitch-free
      // and hold steady while a request is stalled.
      op_d = opcode_e'(ir_d[DATA_W-1 -: OPC_W]);
      case (state_d)
         ST_FETCH: begin
            req_d  = 1'b1;
            addr_d = pc_d;
         end
         ST_EXEC: begin
            req_d  = 1'b1;
            addr_d = ir_d[ADDR_W-1:0];
            if (op_d == OP_STO) begin
               we_d    = 1'b1;
               wdata_d = acc_d;
            end
         end
         default: begin
            req_d = 1'b0;
            we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         pc_q    <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign pc            = pc_q;
   assign acc           = acc_q;
   assign halted        = (state_q == ST_HALT);
   assign err           = err_q;

endmodule

// File: doc/fb_cpu_gen2.md
FB_CPU_GEN2 -- requirements
Module: fb_cpu_gen2

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: memory address width and operand field width.
REQ-002 SHALL have parameter DATA_W, default 10: word, ACC and IR width; elaboration SHALL fail if DATA_W < ADDR_W+4.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-low.
REQ-005 SHALL have port run, input, 1: level; resumes execution from HALT.
REQ-006 SHALL have port mem_req, output, 1: memory request valid.
REQ-007 SHALL have port mem_we, output, 1: request is a write.
REQ-008 SHALL have port mem_addr, output, ADDR_W: request address.
REQ-009 SHALL have port mem_wdata, output, DATA_W: write data.
REQ-010 SHALL have port mem_ready, input, 1: request accepted/completed this cycle.
REQ-011 SHALL have port mem_rdata, input, DATA_W: read data, valid when mem_req && mem_ready && !mem_we.
REQ-012 SHALL have port pc, output, ADDR_W: program counter.
REQ-013 SHALL have port acc, output, DATA_W: accumulator.
REQ-014 SHALL have port halted, output, 1: high in HALT state.
REQ-015 SHALL have port err, output, 1: sticky fault flag.

Function
REQ-016 SHALL decode IR[DATA_W-1:DATA_W-4] as opcode and IR[ADDR_W-1:0] as operand; other bits ignored.
REQ-017 SHALL implement opcodes: 0 LOD, 1 STO, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 JMP, 7 JMZ, 8 NOP, 9 HLT, 10 AND, 11 OR, 12 JMN (jump if acc MSB=1); 13-15 illegal.
REQ-018 SHALL use states FETCH, DECODE, EXEC, HALT: FETCH->DECODE on accepted fetch; DECODE->EXEC for opcodes 0-5,10,11; DECODE->FETCH for 6,7,8,12; DECODE->HALT for 9 and 13-15; EXEC->FETCH on accepted access; HALT->FETCH when run=1.
REQ-019 SHALL in FETCH drive mem_req=1, mem_we=0, mem_addr=pc; on mem_ready load IR from mem_rdata and set pc=pc+1 modulo 2^ADDR_W.
REQ-020 SHALL hold mem_req, mem_we, mem_addr, mem_wdata stable while mem_req=1 and mem_ready=0; mem_req SHALL be 0 in DECODE and HALT.
REQ-021 SHALL in EXEC drive mem_addr=operand; STO drives mem_we=1, mem_wdata=acc; all others read and update acc on mem_ready.
REQ-022 SHALL compute ADD/SUB modulo 2^DATA_W, MUL as low DATA_W bits of unsigned product, AND/OR bitwise, all unsigned.
REQ-023 SHALL resolve JMP/JMZ/JMN in DECODE: taken -> pc=operand, else pc unchanged; one DECODE cycle, no memory access.
REQ-024 SHALL on illegal opcode set err=1 and enter HALT; pc points past the illegal word.
REQ-025 SHALL give minimum latency 3 cycles for memory ops, 2 for branches/NOP, each mem_ready=0 cycle adding one.
REQ-026 SHALL leave mem_ready ignored when mem_req=0.

Reset
REQ-027 SHALL on rst=0, asynchronously: state=FETCH, pc=0, acc=0, IR=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-028 SHALL abandon any outstanding request on reset mid-access; no acc/pc/memory update from it; first request after release is fetch at address 0.

Configuration
REQ-029 SHALL with FB_CPU_DIV_EN defined make DIV acc=acc/operand unsigned, divide-by-zero giving acc=all ones and err=1, execution continuing.
REQ-030 SHALL without FB_CPU_DIV_EN treat opcode 5 as illegal per REQ-024, with no divider logic present.

Structure
REQ-031 SHALL place opcode enum, state enum and opcode field width constant (4) in shared package fb_cpu_pkg.
REQ-032 SHALL instantiate sub-module fb_cpu_alu (combinational: opcode, acc, operand data -> result, div-by-zero flag).

Verification
REQ-033 SHALL cover: [50]=5,[51]=10, program LOD 50; ADD 51; STO 52; HLT, mem_ready=1 -> [52]=15, halted=1, pc=4.
REQ-034 SHALL cover: same program with MUL -> [52]=50; with mem_ready random 0-3 wait cycles -> identical result, stalled outputs stable.
REQ-035 SHALL cover: loop summing 5 ten times via SUB/JMZ/JMP -> [52]=50, err=0.
REQ-036 SHALL cover: with FB_CPU_DIV_EN, LOD 50; DIV 53 ([53]=0) -> acc=all ones, err=1, continues; without the macro -> halted=1, err=1, pc=2.
REQ-037 SHALL cover: opcode 13 at address 0 -> halted=1, err=1; raise run -> fetch from pc=1.
REQ-038 SHALL cover: assert rst during EXEC of STO with mem_ready=0 -> outputs per REQ-027 immediately, target word unchanged.
